// File: rtl/mem_responder_pkg.sv
// mem_map_pkg: MMIO address map shared by the memory responder and its users.
// Holds the MMIO base, register offsets, TXSTAT bit positions and a decode
// helper that turns an MMIO offset into a register selector.
package mem_map_pkg;

   localparam logic [31:0] MMIO_BASE    = 32'h8000_0000;

   localparam logic [7:0]  OFF_LED      = 8'h00;
   localparam logic [7:0]  OFF_TXDATA   = 8'h04;
   localparam logic [7:0]  OFF_TXSTAT   = 8'h08;
   localparam logic [7:0]  OFF_CYCLE_LO = 8'h0C;
   localparam logic [7:0]  OFF_CYCLE_HI = 8'h10;

   // TXSTAT layout: {overflow, 23'b0, count[5:0], full, empty}
   localparam int TXSTAT_EMPTY_BIT = 0;
   localparam int TXSTAT_FULL_BIT  = 1;
   localparam int TXSTAT_COUNT_LSB = 2;
   localparam int TXSTAT_COUNT_W   = 6;
   localparam int TXSTAT_OVF_BIT   = 31;

   typedef enum logic [2:0] {
      REG_LED,
      REG_TXDATA,
      REG_TXSTAT,
      REG_CYCLE_LO,
      REG_CYCLE_HI,
      REG_NONE
   } mmio_reg_e;

   function automatic mmio_reg_e decode_mmio(input logic [7:0] off);
      mmio_reg_e r;
      case (off)
         OFF_LED:      r = REG_LED;
         OFF_TXDATA:   r = REG_TXDATA;
         OFF_TXSTAT:   r = REG_TXSTAT;
         OFF_CYCLE_LO: r = REG_CYCLE_LO;
         OFF_CYCLE_HI: r = REG_CYCLE_HI;
         default:      r = REG_NONE;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: the core's memory bus.
//   Address   byte address from the core
//   WriteData store data, already lane-aligned
//   MemWrite  one-cycle write strobe per store
//   WriteMask byte enables, bit i covers WriteData[8i+7:8i]
//   ReadData  registered read data, valid the cycle after the address
// There is no valid/ready pairing on this bus: every cycle with MemWrite=0 is
// a read and every cycle with MemWrite=1 is a write; the responder never stalls.
interface mem_responder_if;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic        MemWrite;
   logic [3:0]  WriteMask;
   logic [31:0] ReadData;

   modport master (output Address, WriteData, MemWrite, WriteMask, input ReadData);
   modport slave  (input Address, WriteData, MemWrite, WriteMask, output ReadData);
endinterface

// File: rtl/mem_responder_console_fifo.sv
// console_fifo: synchronous FIFO buffering console TX bytes.
//   clk, reset        clock, asynchronous active-low reset (flushes the FIFO)
//   push, push_data   write side; push while full is ignored unless a pop
//                     happens on the same edge
//   full              no free entry
//   pop               read side; only effective when not empty
//   head              oldest entry, 0 when empty
//   empty, count      occupancy
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module console_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   output logic                     full,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count   = wr_ptr - rd_ptr;
   assign do_pop  = pop & ~empty;
   // A pop on the same edge frees the slot the push lands in.
   assign do_push = push & (~full | do_pop);
   assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multicycle core.
//   clk, reset     clock, asynchronous active-low reset
//   bus            core bus (slave side): Address/WriteData/MemWrite/
//                  WriteMask in, registered ReadData out
//   leds           LED register
//   tx_data        console byte at FIFO head
//   tx_valid       console FIFO non-empty
//   tx_ready       console sink accepts the head byte
// Address[31]=0 selects the word RAM (aliased modulo its size), Address[31]=1
// selects the MMIO page decoded from Address[7:0].
module mem_responder
   import mem_map_pkg::*;
#(
   parameter int    RAM_WORDS  = 1024,
   parameter string INIT_FILE  = "",
   parameter int    FIFO_DEPTH = 8
) (
   input  logic           clk,
   input  logic           reset,
   mem_responder_if.slave bus,
   output logic [7:0]     leds,
   output logic [7:0]     tx_data,
   output logic           tx_valid,
   input  logic           tx_ready
);
   localparam int IW = $clog2(RAM_WORDS);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]   ram [RAM_WORDS];
   logic [31:0]   read_data;
   logic [31:0]   hi_snap;
   logic [31:0]   mmio_rdata;
   logic [31:0]   rd_next;
   logic [63:0]   cycle_cnt;
   logic          overflow;
   logic          is_mmio;
   logic [IW-1:0] word_idx;
   mmio_reg_e     reg_sel;
   logic          rd_en;
   logic          wr_ram;
   logic          wr_led;
   logic          push_req;
   logic          clr_ovf;
   logic          pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic          unused_addr;

   assign is_mmio     = bus.Address[31];
   assign word_idx    = bus.Address[IW+1:2];
   assign reg_sel     = decode_mmio(bus.Address[7:0]);
   assign unused_addr = ^bus.Address[30:IW+2];

   assign rd_en    = ~bus.MemWrite;
   assign wr_ram   = bus.MemWrite & ~is_mmio;
   assign wr_led   = bus.MemWrite & is_mmio & (reg_sel == REG_LED) & bus.WriteMask[0];
   assign push_req = bus.MemWrite & is_mmio & (reg_sel == REG_TXDATA) & bus.WriteMask[0];
   assign clr_ovf  = bus.MemWrite & is_mmio & (reg_sel == REG_TXSTAT)
                     & bus.WriteMask[3] & bus.WriteData[31];

   assign tx_valid = ~fifo_empty;
   assign pop      = tx_ready & ~fifo_empty;

   console_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_req),
      .push_data (bus.WriteData[7:0]),
      .full      (fifo_full),
      .pop       (pop),
      .head      (tx_data),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (wr_ram) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.WriteMask[i]) ram[word_idx][8*i +: 8] <= bus.WriteData[8*i +: 8];
         end
      end
   end

   always_comb begin
      mmio_rdata = '0;
      case (reg_sel)
         REG_LED:      mmio_rdata = {24'b0, leds};
         REG_TXSTAT: begin
            mmio_rdata[TXSTAT_OVF_BIT]                           = overflow;
            mmio_rdata[TXSTAT_COUNT_LSB +: TXSTAT_COUNT_W]       = TXSTAT_COUNT_W'(fifo_count);
            mmio_rdata[TXSTAT_FULL_BIT]                          = fifo_full;
            mmio_rdata[TXSTAT_EMPTY_BIT]                         = fifo_empty;
         end
         REG_CYCLE_LO: mmio_rdata = cycle_cnt[31:0];
         REG_CYCLE_HI: mmio_rdata = hi_snap;
         default:      mmio_rdata = '0;
      endcase
   end

   assign rd_next      = is_mmio ? mmio_rdata : ram[word_idx];
   assign bus.ReadData = read_data;

   // hi_snap is captured together with the LO read so a LO-then-HI sequence
   // returns a coherent 64-bit value even if the counter carries in between.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         read_data <= '0;
         hi_snap   <= '0;
      end else if (rd_en) begin
         read_data <= rd_next;
         if (is_mmio && reg_sel == REG_CYCLE_LO) hi_snap <= cycle_cnt[63:32];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         leds      <= '0;
         overflow  <= 1'b0;
         cycle_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 64'd1;
         if (wr_led) leds <= bus.WriteData[7:0];
         // A push into a full FIFO is only dropped when no pop frees a slot.
         if (clr_ovf) overflow <= 1'b0;
         else if (push_req && fifo_full && !pop) overflow <= 1'b1;
      end
   end

endmodule
